// File: rtl/store_buffer.sv
// store_buffer: in-order queue of formatted stores between the store pipeline
// and the data-memory write port. Drains the head entry whenever memory accepts
// it and flags loads whose bytes overlap any pending or enqueuing store.
module store_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_enq_valid,
    output logic                       o_enq_ready,
    input  logic [XLEN-1:0]            i_enq_address,
    input  logic [XLEN-1:0]            i_enq_data,
    input  logic [3:0]                 i_enq_byte_enable,
    input  logic                       i_load_valid,
    input  logic [XLEN-1:0]            i_load_address,
    input  logic [3:0]                 i_load_byte_mask,
    output logic                       o_load_hazard,
    output logic                       o_mem_write_valid,
    input  logic                       i_mem_write_ready,
    output logic [XLEN-1:0]            o_mem_address,
    output logic [XLEN-1:0]            o_mem_write_data,
    output logic [3:0]                 o_mem_byte_write_enable,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int AW = XLEN - 2;

    // Word address match with at least one shared byte lane.
    function automatic logic bytes_overlap(
        input logic [AW-1:0] st_word,
        input logic [3:0]    st_be,
        input logic [AW-1:0] ld_word,
        input logic [3:0]    ld_mask
    );
        return (st_word == ld_word) && ((st_be & ld_mask) != 4'b0000);
    endfunction

    // Entry storage (word address only; the low two address bits are always 0)
    logic [AW-1:0]   addr_q [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [3:0]      be_q   [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic             enq_fire_s;
    logic             enq_write_s;
    logic             deq_fire_s;
    logic             empty_s;
    logic [DEPTH-1:0] entry_valid_s;
    logic             unused_s;

    // Byte offsets within the word are dropped: entries are word-aligned.
    assign unused_s = ^{i_enq_address[1:0], i_load_address[1:0]};

    assign empty_s     = (count_q == {CW{1'b0}});
    assign o_empty     = empty_s;
    assign o_count     = count_q;
    assign o_enq_ready = (count_q != CW'(DEPTH));

    // Handshakes; zero-strobe stores complete the handshake but are never written.
    always_comb begin
        enq_fire_s  = i_enq_valid & o_enq_ready;
        enq_write_s = enq_fire_s & (i_enq_byte_enable != 4'b0000);
        deq_fire_s  = ~empty_s & i_mem_write_ready;
    end

    // Pointer and occupancy next-state.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (deq_fire_s) begin
            head_d = head_q + PW'(1);
        end else begin
            head_d = head_q;
        end
        if (enq_write_s) begin
            tail_d = tail_q + PW'(1);
        end else begin
            tail_d = tail_q;
        end
        case ({enq_write_s, deq_fire_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head_q  <= {PW{1'b0}};
            tail_q  <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payload registers, written at the tail on an accepted non-empty store.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= {AW{1'b0}};
                data_q[i] <= {XLEN{1'b0}};
                be_q[i]   <= 4'b0000;
            end
        end else if (enq_write_s) begin
            addr_q[tail_q] <= i_enq_address[XLEN-1:2];
            data_q[tail_q] <= i_enq_data;
            be_q[tail_q]   <= i_enq_byte_enable;
        end
    end

    // Entry i is live when its distance from head (mod DEPTH) is below count.
    always_comb begin
        logic [PW-1:0] off;
        off           = {PW{1'b0}};
        entry_valid_s = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            off              = PW'(i) - head_q;
            entry_valid_s[i] = ({1'b0, off} < count_q);
        end
    end

    // Load hazard: any live entry (even one draining now) or the store being written now.
    always_comb begin
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid_s[i] &&
                bytes_overlap(addr_q[i], be_q[i], i_load_address[XLEN-1:2], i_load_byte_mask)) begin
                hit = 1'b1;
            end else begin
                hit = hit;
            end
        end
        if (enq_write_s &&
            bytes_overlap(i_enq_address[XLEN-1:2], i_enq_byte_enable,
                          i_load_address[XLEN-1:2], i_load_byte_mask)) begin
            hit = 1'b1;
        end else begin
            hit = hit;
        end
        o_load_hazard = i_load_valid & hit;
    end

    // Memory port presents the head entry straight from its registers; zeros when empty.
    always_comb begin
        if (empty_s) begin
            o_mem_write_valid       = 1'b0;
            o_mem_address           = {XLEN{1'b0}};
            o_mem_write_data        = {XLEN{1'b0}};
            o_mem_byte_write_enable = 4'b0000;
        end else begin
            o_mem_write_valid       = 1'b1;
            o_mem_address           = {addr_q[head_q], 2'b00};
            o_mem_write_data        = data_q[head_q];
            o_mem_byte_write_enable = be_q[head_q];
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: directed stores push expected memory
// writes; a negedge monitor pops and compares each accepted write.
module tb_store_buffer;

    logic        clk;
    logic        rst_n;
    logic        enq_valid;
    logic        enq_ready;
    logic [31:0] enq_addr;
    logic [31:0] enq_data;
    logic [3:0]  enq_be;
    logic        load_valid;
    logic [31:0] load_addr;
    logic [3:0]  load_mask;
    logic        hazard;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [3:0]  mem_be;
    logic [2:0]  count;
    logic        empty;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    store_buffer #(.XLEN(32), .DEPTH(4)) dut (
        .i_clk                  (clk),
        .i_rst_n                (rst_n),
        .i_enq_valid            (enq_valid),
        .o_enq_ready            (enq_ready),
        .i_enq_address          (enq_addr),
        .i_enq_data             (enq_data),
        .i_enq_byte_enable      (enq_be),
        .i_load_valid           (load_valid),
        .i_load_address         (load_addr),
        .i_load_byte_mask       (load_mask),
        .o_load_hazard          (hazard),
        .o_mem_write_valid      (mem_valid),
        .i_mem_write_ready      (mem_ready),
        .o_mem_address          (mem_addr),
        .o_mem_write_data       (mem_data),
        .o_mem_byte_write_enable(mem_be),
        .o_count                (count),
        .o_empty                (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Monitor: compare each accepted write against the scoreboard, and check
    // that a stalled head stays stable until accepted.
    logic        stall_seen = 1'b0;
    logic [31:0] stall_a, stall_d;
    logic [3:0]  stall_be;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_seen = 1'b0;
        end else begin
            if (stall_seen && mem_valid) begin
                chk("stall_addr", mem_addr, stall_a);
                chk("stall_data", mem_data, stall_d);
                chk("stall_be", {28'd0, mem_be}, {28'd0, stall_be});
            end
            if (mem_valid && mem_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: addr 0x%08h data 0x%08h with nothing expected", mem_addr, mem_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("wr_addr", mem_addr, e.a);
                    chk("wr_data", mem_data, e.d);
                    chk("wr_be", {28'd0, mem_be}, {28'd0, e.be});
                end
            end
            stall_seen = mem_valid && !mem_ready;
            stall_a    = mem_addr;
            stall_d    = mem_data;
            stall_be   = mem_be;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one store (called just after a posedge); expects it to be accepted at the next edge.
    task automatic enq_one(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        exp_t e;
        enq_valid = 1'b1;
        enq_addr  = a;
        enq_data  = d;
        enq_be    = be;
        @(negedge clk);
        chk("enq_ready", {31'd0, enq_ready}, 32'd1);
        if (be != 4'b0000) begin
            e.a  = {a[31:2], 2'b00};
            e.d  = d;
            e.be = be;
            sb.push_back(e);
        end
        tick();
        enq_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (!empty && n < 40) begin
            tick();
            n++;
        end
        chk("drain_done", {31'd0, empty}, 32'd1);
    endtask

    initial begin
        exp_t e;
        int   k;
        logic [2:0] cnt_before;
        logic       both;
        rst_n      = 1'b0;
        enq_valid  = 1'b0;
        enq_addr   = 32'd0;
        enq_data   = 32'd0;
        enq_be     = 4'b0000;
        load_valid = 1'b0;
        load_addr  = 32'd0;
        load_mask  = 4'b0000;
        mem_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_ready", {31'd0, enq_ready}, 32'd1);
        chk("rst_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_hazard", {31'd0, hazard}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single store, memory ready: valid one cycle after enqueue, empty the cycle after.
        mem_ready = 1'b1;
        enq_one(32'h0000_1000, 32'hDEAD_BEEF, 4'b1111);
        @(negedge clk);
        chk("lat_valid", {31'd0, mem_valid}, 32'd1);
        tick();
        @(negedge clk);
        chk("empty_after", {31'd0, empty}, 32'd1);
        tick();

        // Fill to DEPTH with memory stalled; 5th store waits for the first dequeue.
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            enq_one(32'h0000_0100 + 32'(i * 16) + 32'(i), 32'hA000_0000 + 32'(i), 4'b1111);
        end
        enq_valid = 1'b1;
        enq_addr  = 32'h0000_0150;
        enq_data  = 32'hA000_0004;
        enq_be    = 4'b0011;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("full_ready", {31'd0, enq_ready}, 32'd0);
        chk("full_count", {29'd0, count}, 32'd4);
        tick();
        @(negedge clk);
        chk("ready_back", {31'd0, enq_ready}, 32'd1);
        chk("count_3", {29'd0, count}, 32'd3);
        e.a = 32'h0000_0150; e.d = 32'hA000_0004; e.be = 4'b0011;
        sb.push_back(e);
        tick();
        enq_valid = 1'b0;
        chk("count_enq_deq", {29'd0, count}, 32'd3);
        wait_empty();

        // Zero-strobe store: accepted, not written.
        mem_ready = 1'b0;
        enq_one(32'h0000_0500, 32'h1111_1111, 4'b1111);
        enq_one(32'h0000_0504, 32'h2222_2222, 4'b1000);
        enq_one(32'h0000_0508, 32'h3333_3333, 4'b0000);
        @(negedge clk);
        chk("zero_be_count", {29'd0, count}, 32'd2);
        tick();
        mem_ready = 1'b1;
        wait_empty();

        // Hazard detection against a pending byte store at 0x2002.
        mem_ready = 1'b0;
        enq_one(32'h0000_2002, 32'h00AB_0000, 4'b0100);
        load_valid = 1'b1; load_addr = 32'h0000_2000; load_mask = 4'b0100;
        @(negedge clk);
        chk("hz_match", {31'd0, hazard}, 32'd1);
        tick();
        load_mask = 4'b0011;
        @(negedge clk);
        chk("hz_lane_miss", {31'd0, hazard}, 32'd0);
        tick();
        load_addr = 32'h0000_2004; load_mask = 4'b0100;
        @(negedge clk);
        chk("hz_word_miss", {31'd0, hazard}, 32'd0);
        tick();
        load_valid = 1'b0; load_addr = 32'h0000_2000;
        @(negedge clk);
        chk("hz_no_load", {31'd0, hazard}, 32'd0);
        tick();
        load_valid = 1'b1; load_addr = 32'h0000_3000; load_mask = 4'b0001;
        enq_valid = 1'b1; enq_addr = 32'h0000_3000; enq_data = 32'h0000_00CC; enq_be = 4'b0001;
        @(negedge clk);
        chk("hz_enq_same_cycle", {31'd0, hazard}, 32'd1);
        e.a = 32'h0000_3000; e.d = 32'h0000_00CC; e.be = 4'b0001;
        sb.push_back(e);
        tick();
        load_addr = 32'h0000_4000; load_mask = 4'b1111;
        enq_addr = 32'h0000_4000; enq_be = 4'b0000;
        @(negedge clk);
        chk("hz_zero_be_enq", {31'd0, hazard}, 32'd0);
        tick();
        enq_valid = 1'b0;
        load_addr = 32'h0000_2000; load_mask = 4'b0100;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("hz_deq_cycle", {31'd0, hazard}, 32'd1);
        tick();
        mem_ready = 1'b0;
        @(negedge clk);
        chk("hz_cleared", {31'd0, hazard}, 32'd0);
        tick();
        load_valid = 1'b0;
        mem_ready  = 1'b1;
        wait_empty();

        // Memory ready toggling every cycle with continuous enqueues.
        k = 0;
        for (int c = 0; c < 60 && (k < 8 || !empty); c++) begin
            mem_ready = c[0];
            if (k < 8) begin
                enq_valid = 1'b1;
                enq_addr  = 32'h0000_6000 + 32'(k * 4);
                enq_data  = 32'h5500_0000 + 32'(k * 32'h0101);
                enq_be    = (k % 3 == 0) ? 4'b1111 : ((k % 3 == 1) ? 4'b0110 : 4'b1000);
            end else begin
                enq_valid = 1'b0;
            end
            @(negedge clk);
            cnt_before = count;
            both = enq_valid && enq_ready && mem_valid && mem_ready;
            if (enq_valid && enq_ready) begin
                e.a = enq_addr; e.d = enq_data; e.be = enq_be;
                sb.push_back(e);
                k++;
            end
            tick();
            if (both) chk("count_const", {29'd0, count}, {29'd0, cnt_before});
        end
        enq_valid = 1'b0;
        chk("toggle_issued", 32'(k), 32'd8);
        wait_empty();

        // Reset while three entries are pending and the head write is stalled.
        mem_ready = 1'b0;
        enq_one(32'h0000_7000, 32'h7000_0001, 4'b1111);
        enq_one(32'h0000_7004, 32'h7000_0002, 4'b1111);
        enq_one(32'h0000_7008, 32'h7000_0003, 4'b1111);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, mem_valid}, 32'd0);
        chk("mid_rst_addr", mem_addr, 32'd0);
        chk("mid_rst_data", mem_data, 32'd0);
        chk("mid_rst_be", {28'd0, mem_be}, 32'd0);
        chk("mid_rst_count", {29'd0, count}, 32'd0);
        chk("mid_rst_empty", {31'd0, empty}, 32'd1);
        chk("mid_rst_ready", {31'd0, enq_ready}, 32'd1);
        sb.delete();
        @(negedge clk);
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        repeat (5) tick();
        chk("post_rst_valid", {31'd0, mem_valid}, 32'd0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Store buffer between the EX/MA store path and the data-memory write port. It queues aligned stores after address and byte-lane formatting: address, aligned write data, and per-byte write enables, including successful SC.W. It drains them in program order whenever the memory port accepts a write. It also flags loads that overlap pending stores so the pipeline can stall them until the conflicting store has drained.

## Interface
Parameters:
- XLEN, 32, data/address width (only 32 supported; byte enables fixed at 4 bits)
- DEPTH, 4, entry count; power of two, ≥2

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_enq_valid  in  1  store presented for enqueue
- o_enq_ready  out  1  buffer can accept a store this cycle
- i_enq_address  in  XLEN  effective store address (bits [1:0] ignored; stored word-aligned)
- i_enq_data  in  XLEN  lane-aligned write data
- i_enq_byte_enable  in  4  per-byte strobes
- i_load_valid  in  1  load lookup this cycle
- i_load_address  in  XLEN  load effective address
- i_load_byte_mask  in  4  bytes the load reads
- o_load_hazard  out  1  load overlaps a pending or enqueuing store
- o_mem_write_valid  out  1  head entry offered to memory
- i_mem_write_ready  in  1  memory accepts write this cycle
- o_mem_address  out  XLEN  head address, bits [1:0] = 0
- o_mem_write_data  out  XLEN  head data
- o_mem_byte_write_enable  out  4  head strobes
- o_count  out  $clog2(DEPTH+1)  occupied entries
- o_empty  out  1  o_count == 0

## Operation
- Circular FIFO: head/tail pointers of $clog2(DEPTH) bits wrapping modulo DEPTH, plus an occupancy counter. Entries are registered.
- Enqueue fires on i_enq_valid & o_enq_ready. o_enq_ready = (count != DEPTH). There is no same-cycle pass-through when full, even if a dequeue fires in that cycle.
- A store with i_enq_byte_enable == 4'b0000 (failed SC.W, STN) is accepted (handshake completes) but not written; tail and count are unchanged.
- Dequeue fires on o_mem_write_valid & i_mem_write_ready. o_mem_write_valid = !o_empty.
- Memory outputs come directly from the head entry. They stay stable while valid and not ready. When the buffer is empty, address, data and strobes are driven to 0.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- Ordering is strict FIFO. No coalescing of stores to the same word.
- Hazard detection (combinational): o_load_hazard = i_load_valid & (any valid entry, or the enqueue firing this cycle, has address[XLEN-1:2] == i_load_address[XLEN-1:2] and (byte_enable & i_load_byte_mask) != 0).
  - An entry dequeued this same cycle still counts. This is a conservative rule.
  - Zero-strobe enqueues never match.
- Entry valid bits are derived from pointers and count; entries beyond the count never match.

## Timing
- Reset (asynchronous assert, synchronous deassert expected upstream):
  - pointers = 0, count = 0
  - o_empty = 1, o_enq_ready = 1
  - o_mem_write_valid = 0, o_mem_address/o_mem_write_data/o_mem_byte_write_enable = 0
  - o_load_hazard = 0 (when i_load_valid = 0)
  - Pending entries are discarded.
- Asserting reset mid-drain drops any in-flight handshake; no write is issued after reset asserts.
- Enqueue-to-memory latency: a store enqueued into an empty buffer at cycle N gives o_mem_write_valid = 1 at N+1.
- Drain throughput: one entry per cycle while i_mem_write_ready stays high.
- o_enq_ready, o_count and o_empty are registered-state functions only. They carry no combinational path from i_mem_write_ready.
- o_load_hazard is same-cycle combinational from i_load_* and i_enq_*.
- Full boundary: the cycle after count reaches DEPTH, o_enq_ready = 0. It reasserts the cycle after the first dequeue.
- Empty boundary: o_empty rises the cycle after the last dequeue, unless an enqueue fires in that same cycle.

## Test plan
- Reset then single SW to 0x1000, data 0xDEADBEEF, be 4'b1111, mem ready high -> o_mem_write_valid high exactly one cycle after enqueue, address 0x1000, data/be match; o_empty returns to 1 the following cycle.
- DEPTH=4, mem ready low, enqueue 5 stores back-to-back -> first 4 accepted, o_enq_ready = 0 on the 5th, o_count = 4. Raise ready -> drained in enqueue order at one per cycle, pointers wrap, and the 5th store is accepted after the first dequeue.
- Enqueue with be 4'b0000 while other stores are pending -> handshake completes, o_count unchanged, no memory write issued for it.
- Pending SB at 0x2002 (be 4'b0100): load 0x2000 mask 4'b0100 -> hazard = 1; mask 4'b0011 -> 0; load 0x2004 mask 4'b0100 -> 0; hazard clears the cycle after that entry dequeues.
- Mem ready toggling every cycle with continuous enqueues -> outputs stable while stalled; no loss or duplication; simultaneous enqueue/dequeue keeps o_count constant.
- Assert i_rst_n low with 3 entries pending and a write stalled -> all outputs return to reset values immediately; no further writes issued after release.
